// File: rtl/mem_io_responder_if.sv
// CPU byte-bus plus board UART signals seen by the memory/IO responder.
// The responder uses the slave modport; the CPU/board side uses master.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: 128 KB RAM plus MMIO (UART TX FIFO, RX byte, cycle counter, stop flag).
// Latency: mem_din registered, valid the cycle after the address; rx_pop is same-cycle.
// Backpressure: TX FIFO drains on tx_valid & tx_ready, io_buffer_full one slot early. Option macro: STOP_DRAIN_EN.
module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXF_AW    = 4,
  parameter int TXF_DEPTH = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);
  localparam int              RAM_WORDS     = 1 << RAM_AW;
  localparam logic [TXF_AW:0] FULL_CNT      = (TXF_AW+1)'(TXF_DEPTH);
  localparam logic [TXF_AW:0] NEAR_FULL_CNT = (TXF_AW+1)'(TXF_DEPTH - 1);

  logic [7:0]        ram [RAM_WORDS];
  logic [7:0]        txf [TXF_DEPTH];
  logic [TXF_AW-1:0] wptr, rptr;
  logic [TXF_AW:0]   count, count_nx;
  logic [31:0]       cyc, snap;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       off;
  logic              io, rd_rx, push_req, push_ok, pop, stop_req;
  logic [7:0]        push_dat;
`ifdef STOP_DRAIN_EN
  logic              stop_pending;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.mem_a[31:18]};

  assign io      = (bus.mem_a[17:16] == 2'b11);
  assign ram_idx = bus.mem_a[RAM_AW-1:0];
  assign off     = bus.mem_a[15:0];
  assign rd_rx   = io && !bus.mem_wr && (off == 16'h0000);

  assign bus.rx_pop   = !rst_in && rd_rx && bus.rx_valid;
  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = txf[rptr];

  // The 0x30004 stop marker bypasses the zero filter so the UART sees a trailing 00.
  always_comb begin
    push_req = 1'b0;
    push_dat = bus.mem_dout;
    stop_req = 1'b0;
    if (io && bus.mem_wr) begin
      if (off == 16'h0000) begin
        push_req = (bus.mem_dout != 8'h00);
      end else if (off == 16'h0004) begin
        push_req = 1'b1;
        push_dat = 8'h00;
        stop_req = 1'b1;
      end
    end
  end

  // A push while full is dropped even if a pop frees a slot at the same edge.
  assign pop     = bus.tx_valid && bus.tx_ready;
  assign push_ok = push_req && (count != FULL_CNT);

  always_comb begin
    count_nx = count;
    if (push_ok && !pop) begin
      count_nx = count + (TXF_AW+1)'(1);
    end else if (!push_ok && pop) begin
      count_nx = count - (TXF_AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && bus.mem_wr && !io) begin
      ram[ram_idx] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.mem_din        <= 8'h00;
      bus.io_buffer_full <= 1'b0;
      bus.program_stop   <= 1'b0;
      wptr               <= '0;
      rptr               <= '0;
      count              <= '0;
      cyc                <= 32'd0;
      snap               <= 32'd0;
      for (int i = 0; i < TXF_DEPTH; i++) begin
        txf[i] <= 8'h00;
      end
`ifdef STOP_DRAIN_EN
      stop_pending       <= 1'b0;
`endif
    end else begin
      cyc <= cyc + 32'd1;

      if (!bus.mem_wr) begin
        if (!io) begin
          bus.mem_din <= ram[ram_idx];
        end else begin
          case (off)
            16'h0000: bus.mem_din <= bus.rx_valid ? bus.rx_data : 8'h00;
            16'h0004: begin
              bus.mem_din <= cyc[7:0];
              snap        <= cyc;
            end
            16'h0005: bus.mem_din <= snap[15:8];
            16'h0006: bus.mem_din <= snap[23:16];
            16'h0007: bus.mem_din <= snap[31:24];
            default:  bus.mem_din <= 8'h00;
          endcase
        end
      end

      if (push_ok) begin
        txf[wptr] <= push_dat;
        wptr      <= wptr + TXF_AW'(1);
      end
      if (pop) begin
        rptr <= rptr + TXF_AW'(1);
      end
      count              <= count_nx;
      bus.io_buffer_full <= (count_nx >= NEAR_FULL_CNT);

`ifdef STOP_DRAIN_EN
      // Stop only once the trailing 00 has left the FIFO.
      if (stop_req) begin
        stop_pending <= 1'b1;
      end
      if (stop_pending && (count_nx == '0)) begin
        bus.program_stop <= 1'b1;
      end
`else
      if (stop_req) begin
        bus.program_stop <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: per-feature tasks against a queue/array reference model.
module tb_mem_io_responder;
  logic clk = 1'b0;
  logic rst;
  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .TXF_AW(4), .TXF_DEPTH(16)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  logic [7:0]  m_din;
  bit          m_known;
  logic [31:0] m_cyc, m_snap;
  bit          m_full, m_stop, m_pending;

  task automatic set_in(input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_wr   = w;
    bus.mem_dout = d;
  endtask

  task automatic idle_in();
    set_in(32'h0, 1'b0, 8'h00);
  endtask

  // Predicts the effect of the coming edge from the current inputs, then advances to the next negedge.
  task automatic tick();
    logic [31:0] a;
    logic [15:0] off;
    logic [7:0]  pd;
    bit          io, pop, push, stop_wr;
    a       = bus.mem_a;
    off     = a[15:0];
    io      = (a[17:16] == 2'b11);
    stop_wr = bus.mem_wr && io && (off == 16'h0004);
    if (rst) begin
      m_din = 8'h00; m_known = 1; txq.delete(); m_cyc = 0; m_snap = 0;
      m_stop = 0; m_pending = 0; m_full = 0;
    end else begin
      if (!bus.mem_wr) begin
        if (!io) begin
          m_known = ram_m.exists(int'(a[16:0]));
          if (m_known) m_din = ram_m[int'(a[16:0])];
        end else begin
          m_known = 1;
          case (off)
            16'h0000: m_din = bus.rx_valid ? bus.rx_data : 8'h00;
            16'h0004: begin m_din = m_cyc[7:0]; m_snap = m_cyc; end
            16'h0005: m_din = m_snap[15:8];
            16'h0006: m_din = m_snap[23:16];
            16'h0007: m_din = m_snap[31:24];
            default:  m_din = 8'h00;
          endcase
        end
      end else if (!io) begin
        ram_m[int'(a[16:0])] = bus.mem_dout;
      end
      pop  = bus.tx_ready && (txq.size() != 0);
      push = bus.mem_wr && io && ((off == 16'h0000 && bus.mem_dout != 8'h00) || off == 16'h0004);
      pd   = (off == 16'h0004) ? 8'h00 : bus.mem_dout;
      if (txq.size() >= 16) push = 0;
      if (pop)  void'(txq.pop_front());
      if (push) txq.push_back(pd);
      m_full = (txq.size() >= 15);
`ifdef STOP_DRAIN_EN
      if (m_pending && txq.size() == 0) m_stop = 1;
      if (stop_wr) m_pending = 1;
`else
      if (stop_wr) m_stop = 1;
`endif
      m_cyc = m_cyc + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (bus.mem_din !== 8'h00) begin n_bad++; $display("FAIL reset_mem_din got=%h exp=00", bus.mem_din); end
    n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", bus.io_buffer_full); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    n_cmp++; if (bus.rx_pop !== 1'b0) begin n_bad++; $display("FAIL reset_rx_pop got=%b exp=0", bus.rx_pop); end
    n_cmp++; if (bus.program_stop !== 1'b0) begin n_bad++; $display("FAIL reset_stop got=%b exp=0", bus.program_stop); end
  endtask

  task automatic test_ram();
    logic [31:0] addrs [24];
    logic [31:0] hi;
    set_in(32'h0000_0010, 1'b1, 8'hA5); tick();
    set_in(32'h0000_0010, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_rd_after_wr got=%h exp=a5", bus.mem_din); end
    set_in(32'h0000_0011, 1'b1, 8'h77); tick();
    n_cmp++; if (bus.mem_din !== 8'hA5) begin n_bad++; $display("FAIL ram_wr_keeps_din got=%h exp=a5", bus.mem_din); end
    set_in(32'hFFF1_FFFF, 1'b1, 8'h3C); tick();
    set_in(32'h0001_FFFF, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'h3C) begin n_bad++; $display("FAIL ram_top_addr got=%h exp=3c", bus.mem_din); end
    for (int i = 0; i < 24; i++) begin
      hi = $urandom;
      addrs[i] = {hi[31:18], 1'b0, 17'($urandom_range(0, 17'h1FFFF))};
      set_in(addrs[i], 1'b1, 8'($urandom)); tick();
    end
    for (int i = 23; i >= 0; i--) begin
      set_in(addrs[i], 1'b0, 8'h00); tick();
      n_cmp++; if (bus.mem_din !== m_din) begin n_bad++; $display("FAIL ram_rand[%0d] a=%h got=%h exp=%h", i, addrs[i], bus.mem_din, m_din); end
    end
    // A RAM write presented together with reset must not land.
    set_in(32'h20, 1'b1, 8'h11); tick();
    rst = 1'b1; set_in(32'h20, 1'b1, 8'h22); tick(); rst = 1'b0;
    set_in(32'h20, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'h11) begin n_bad++; $display("FAIL ram_wr_in_reset got=%h exp=11", bus.mem_din); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    bus.tx_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      set_in(32'h0003_0000, 1'b1, 8'(k)); tick();
      n_cmp++; if (bus.io_buffer_full !== (k >= 15)) begin n_bad++; $display("FAIL fifo_full_after_%0d got=%b exp=%b", k, bus.io_buffer_full, (k >= 15)); end
    end
    set_in(32'h0003_0000, 1'b1, 8'd17); tick();
    idle_in();
    bus.tx_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(k)) begin n_bad++; $display("FAIL fifo_drain_%0d got=%b/%h exp=1/%h", k, bus.tx_valid, bus.tx_data, 8'(k)); end
      tick();
    end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL fifo_empty_after_drain got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_bad++; $display("FAIL fifo_full_after_drain got=%b exp=0", bus.io_buffer_full); end
  endtask

  task automatic test_zero_filter();
    bus.tx_ready = 1'b0;
    set_in(32'h0003_0000, 1'b1, 8'h00); tick();
    idle_in(); tick();
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL zero_byte_pushed got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b1;
    set_in(32'h0003_0000, 1'b1, 8'h41); tick();
    idle_in();
    n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin n_bad++; $display("FAIL tx_41 got=%b/%h exp=1/41", bus.tx_valid, bus.tx_data); end
    tick();
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_41_one_cycle got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 8'h5A : 8'($urandom);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      set_in(32'h0003_0000, 1'b0, 8'h00);
      #1;
      n_cmp++; if (bus.rx_pop !== 1'b1) begin n_bad++; $display("FAIL rx_pop_%0d got=%b exp=1", i, bus.rx_pop); end
      tick();
      n_cmp++; if (bus.mem_din !== b) begin n_bad++; $display("FAIL rx_data_%0d got=%h exp=%h", i, bus.mem_din, b); end
    end
    bus.rx_valid = 1'b0;
    set_in(32'h0003_0000, 1'b0, 8'h00);
    #1;
    n_cmp++; if (bus.rx_pop !== 1'b0) begin n_bad++; $display("FAIL rx_pop_idle got=%b exp=0", bus.rx_pop); end
    tick();
    n_cmp++; if (bus.mem_din !== 8'h00) begin n_bad++; $display("FAIL rx_empty_data got=%h exp=00", bus.mem_din); end
  endtask

  task automatic test_cycle();
    do_reset();
    idle_in();
    repeat (100) tick();
    set_in(32'h0003_0004, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'd100) begin n_bad++; $display("FAIL cyc_byte0 got=%0d exp=100", bus.mem_din); end
    for (int k = 5; k <= 7; k++) begin
      set_in(32'h0003_0000 + 32'(k), 1'b0, 8'h00); tick();
      n_cmp++; if (bus.mem_din !== 8'h00) begin n_bad++; $display("FAIL cyc_byte%0d got=%h exp=00", k - 4, bus.mem_din); end
    end
    set_in(32'h0003_0008, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'h00) begin n_bad++; $display("FAIL io_other_rd got=%h exp=00", bus.mem_din); end
    // Snapshot must hold while the counter runs on.
    idle_in();
    repeat (300) tick();
    set_in(32'h0003_0005, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'h00) begin n_bad++; $display("FAIL snap_held got=%h exp=00", bus.mem_din); end
    set_in(32'h0003_0004, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== m_din) begin n_bad++; $display("FAIL cyc_reread got=%h exp=%h", bus.mem_din, m_din); end
    set_in(32'h0003_0005, 1'b0, 8'h00); tick();
    n_cmp++; if (bus.mem_din !== 8'h01) begin n_bad++; $display("FAIL cyc_byte1_after_256 got=%h exp=01", bus.mem_din); end
  endtask

  task automatic test_stop();
    logic [7:0] b [3];
    logic [7:0] exp_seq [3];
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom_range(1, 255));
      set_in(32'h0003_0000, 1'b1, b[i]); tick();
    end
    bus.tx_ready = 1'b1;
    set_in(32'h0003_0004, 1'b1, 8'($urandom)); tick();
    idle_in();
`ifdef STOP_DRAIN_EN
    n_cmp++; if (bus.program_stop !== 1'b0) begin n_bad++; $display("FAIL stop_at_write got=%b exp=0", bus.program_stop); end
`else
    n_cmp++; if (bus.program_stop !== 1'b1) begin n_bad++; $display("FAIL stop_at_write got=%b exp=1", bus.program_stop); end
`endif
    exp_seq[0] = b[1]; exp_seq[1] = b[2]; exp_seq[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_seq[i]) begin n_bad++; $display("FAIL stop_seq_%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, exp_seq[i]); end
      n_cmp++; if (bus.program_stop !== m_stop) begin n_bad++; $display("FAIL stop_during_drain_%0d got=%b exp=%b", i, bus.program_stop, m_stop); end
      tick();
    end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL stop_fifo_empty got=%b exp=0", bus.tx_valid); end
    n_cmp++; if (bus.program_stop !== 1'b1) begin n_bad++; $display("FAIL stop_final got=%b exp=1", bus.program_stop); end
    // Reset mid-operation: refill, then reset with a push presented.
    bus.tx_ready = 1'b0;
    set_in(32'h0003_0000, 1'b1, 8'h99); tick();
    rst = 1'b1; set_in(32'h0003_0000, 1'b1, 8'h98); tick(); rst = 1'b0;
    idle_in(); tick();
    n_cmp++; if (bus.program_stop !== 1'b0) begin n_bad++; $display("FAIL stop_cleared got=%b exp=0", bus.program_stop); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_flushes_fifo got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_random();
    logic [31:0] hi;
    logic [17:0] a18;
    logic        w;
    logic [7:0]  d;
    bit          exp_pop;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      hi = $urandom;
      w  = 1'b0;
      d  = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2: begin a18 = 18'h100 + 18'($urandom_range(0, 15)); w = 1'b1; end
        3, 4:    a18 = 18'h100 + 18'($urandom_range(0, 15));
        5:       begin a18 = 18'h30000; w = 1'b1; if ($urandom_range(0, 3) == 0) d = 8'h00; end
        6:       a18 = 18'h30000;
        7:       a18 = 18'h30004 + 18'($urandom_range(0, 3));
        8:       begin a18 = 18'h30004; w = ($urandom_range(0, 19) == 0); end
        default: begin a18 = 18'h30000 + 18'($urandom_range(8, 200)); w = 1'($urandom_range(0, 1)); end
      endcase
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
      set_in({hi[31:18], a18}, w, d);
      #1;
      exp_pop = !w && (a18 == 18'h30000) && bus.rx_valid;
      n_cmp++; if (bus.rx_pop !== exp_pop) begin n_bad++; $display("FAIL rnd_rx_pop n=%0d got=%b exp=%b", n, bus.rx_pop, exp_pop); end
      tick();
      if (m_known) begin
        n_cmp++; if (bus.mem_din !== m_din) begin n_bad++; $display("FAIL rnd_mem_din n=%0d got=%h exp=%h", n, bus.mem_din, m_din); end
      end
      n_cmp++; if (bus.tx_valid !== (txq.size() != 0)) begin n_bad++; $display("FAIL rnd_tx_valid n=%0d got=%b exp=%b", n, bus.tx_valid, (txq.size() != 0)); end
      if (txq.size() != 0) begin
        n_cmp++; if (bus.tx_data !== txq[0]) begin n_bad++; $display("FAIL rnd_tx_data n=%0d got=%h exp=%h", n, bus.tx_data, txq[0]); end
      end
      n_cmp++; if (bus.io_buffer_full !== m_full) begin n_bad++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, bus.io_buffer_full, m_full); end
      n_cmp++; if (bus.program_stop !== m_stop) begin n_bad++; $display("FAIL rnd_stop n=%0d got=%b exp=%b", n, bus.program_stop, m_stop); end
    end
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_full();
    test_zero_filter();
    test_rx();
    test_cycle();
    test_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
